// File: rtl/sc_lane_scheduler.sv
// Frogger-style lane scheduler: game FSM, base tick divider,
// per-lane shift strobes, lives/score/level bookkeeping.
module sc_lane_scheduler #(
  parameter int unsigned TICK_DIV     = 5000000,
  parameter int unsigned LANE0_PERIOD = 1,
  parameter int unsigned LANE1_PERIOD = 2,
  parameter int unsigned LANE2_PERIOD = 3,
  parameter int unsigned LANE3_PERIOD = 4,
  parameter int unsigned LIVES_INIT   = 3
) (
  input  logic       SC_LANE_SCHEDULER_CLOCK_50,
  input  logic       SC_LANE_SCHEDULER_RESET_InHigh,
  input  logic       SC_LANE_SCHEDULER_startGame_InLow,
  input  logic       SC_LANE_SCHEDULER_collision_InHigh,
  input  logic       SC_LANE_SCHEDULER_goal_InHigh,
  output logic [3:0] SC_LANE_SCHEDULER_shift_OutLow,
  output logic       SC_LANE_SCHEDULER_loadInit_OutLow,
  output logic       SC_LANE_SCHEDULER_playerReset_OutHigh,
  output logic       SC_LANE_SCHEDULER_playEnable_OutHigh,
  output logic [1:0] SC_LANE_SCHEDULER_lives_Out,
  output logic [7:0] SC_LANE_SCHEDULER_score_Out,
  output logic [1:0] SC_LANE_SCHEDULER_level_Out,
  output logic       SC_LANE_SCHEDULER_gameOver_OutHigh
);

  localparam int unsigned TW =
    (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  localparam logic [15:0] LANE_PER = {
    4'(LANE3_PERIOD), 4'(LANE2_PERIOD),
    4'(LANE1_PERIOD), 4'(LANE0_PERIOD)
  };

  typedef enum logic [2:0] {
    S_RESET    = 3'd0,
    S_IDLE     = 3'd1,
    S_LOAD     = 3'd2,
    S_PLAY     = 3'd3,
    S_HIT      = 3'd4,
    S_WIN      = 3'd5,
    S_GAMEOVER = 3'd6
  } state_e;

  logic clk;
  logic rst;
  logic start_n;
  logic coll;
  logic goal;

  assign clk     = SC_LANE_SCHEDULER_CLOCK_50;
  assign rst     = SC_LANE_SCHEDULER_RESET_InHigh;
  assign start_n = SC_LANE_SCHEDULER_startGame_InLow;
  assign coll    = SC_LANE_SCHEDULER_collision_InHigh;
  assign goal    = SC_LANE_SCHEDULER_goal_InHigh;

  state_e          state_q;
  state_e          state_d;
  logic [TW-1:0]   tick_q;
  logic [TW-1:0]   tick_d;
  logic [3:0][3:0] lane_q;
  logic [3:0][3:0] lane_d;
  logic [3:0][3:0] per_eff;
  logic [3:0]      lane_wrap;
  logic [3:0]      shift_q;
  logic [3:0]      shift_d;
  logic [1:0]      lives_q;
  logic [1:0]      lives_d;
  logic [7:0]      score_q;
  logic [7:0]      score_d;
  logic [1:0]      level_q;
  logic [1:0]      level_d;
  logic            base_tick;
  logic            in_play;
  logic            new_game;

  logic load_n;
  logic player_rst;
  logic play_en;
  logic game_over;

  assign in_play   = (state_q == S_PLAY);
  assign base_tick = in_play && (tick_q == TICK_LAST);
  assign new_game  = (state_d == S_LOAD) &&
                     ((state_q == S_IDLE) ||
                      (state_q == S_GAMEOVER));

  // Game FSM: next state and Moore outputs.
  always_comb begin
    state_d    = state_q;
    load_n     = 1'b1;
    player_rst = 1'b0;
    play_en    = 1'b0;
    game_over  = 1'b0;
    case (state_q)
      S_RESET: state_d = S_IDLE;
      S_IDLE: begin
        if (!start_n) state_d = S_LOAD;
      end
      S_LOAD: begin
        load_n     = 1'b0;
        player_rst = 1'b1;
        state_d    = S_PLAY;
      end
      S_PLAY: begin
        play_en = 1'b1;
        if (coll)      state_d = S_HIT;
        else if (goal) state_d = S_WIN;
      end
      S_HIT: begin
        player_rst = 1'b1;
        state_d = (lives_q == 2'd0) ? S_GAMEOVER
                                    : S_PLAY;
      end
      S_WIN: state_d = S_LOAD;
      S_GAMEOVER: begin
        game_over = 1'b1;
        if (!start_n) state_d = S_LOAD;
      end
      default: state_d = S_RESET;
    endcase
  end

  // Effective lane periods shrink with level; wraps on base tick.
  always_comb begin
    per_eff   = '0;
    lane_wrap = '0;
    for (int i = 0; i < 4; i++) begin
      per_eff[i] = LANE_PER[i*4 +: 4] >> level_q;
      if (per_eff[i] == 4'd0) per_eff[i] = 4'd1;
      lane_wrap[i] = base_tick &&
                     (lane_q[i] == per_eff[i] - 4'd1);
    end
  end

  // Tick divider and lane counters: run in PLAY, clear in LOAD.
  always_comb begin
    tick_d = tick_q;
    lane_d = lane_q;
    if (state_q == S_LOAD) begin
      tick_d = '0;
      lane_d = '0;
    end else if (in_play) begin
      tick_d = (tick_q == TICK_LAST) ? '0
                                     : tick_q + 1'b1;
      if (base_tick) begin
        for (int i = 0; i < 4; i++) begin
          lane_d[i] = lane_wrap[i] ? 4'd0
                                   : lane_q[i] + 4'd1;
        end
      end
    end
  end

  // Strobes follow the wrap by one cycle, active low.
  assign shift_d = ~lane_wrap;

  // Lives, score and level bookkeeping.
  always_comb begin
    lives_d = lives_q;
    score_d = score_q;
    level_d = level_q;
    if (new_game) begin
      lives_d = 2'(LIVES_INIT);
      score_d = 8'd0;
      level_d = 2'd0;
    end else if (in_play && coll) begin
      if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
    end else if (state_q == S_WIN) begin
      if (score_q != 8'hFF) score_d = score_q + 8'd1;
      if (level_q != 2'd3)  level_d = level_q + 2'd1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  // Tick and lane counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
      lane_q <= '0;
    end else begin
      tick_q <= tick_d;
      lane_q <= lane_d;
    end
  end

  // Registered shift strobes.
  always_ff @(posedge clk) begin
    if (rst) shift_q <= 4'b1111;
    else     shift_q <= shift_d;
  end

  // Game progress registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lives_q <= 2'd0;
      score_q <= 8'd0;
      level_q <= 2'd0;
    end else begin
      lives_q <= lives_d;
      score_q <= score_d;
      level_q <= level_d;
    end
  end

  assign SC_LANE_SCHEDULER_shift_OutLow        = shift_q;
  assign SC_LANE_SCHEDULER_loadInit_OutLow     = load_n;
  assign SC_LANE_SCHEDULER_playerReset_OutHigh = player_rst;
  assign SC_LANE_SCHEDULER_playEnable_OutHigh  = play_en;
  assign SC_LANE_SCHEDULER_lives_Out           = lives_q;
  assign SC_LANE_SCHEDULER_score_Out           = score_q;
  assign SC_LANE_SCHEDULER_level_Out           = level_q;
  assign SC_LANE_SCHEDULER_gameOver_OutHigh    = game_over;

endmodule

// File: tb/tb_sc_lane_scheduler.sv
// Directed bench for sc_lane_scheduler with an expectation queue.
// Small TICK_DIV so lane strobe cadence is visible quickly.
module tb_sc_lane_scheduler;

  localparam int TD = 4;
  localparam int LP0 = 1;
  localparam int LP1 = 2;
  localparam int LP2 = 3;
  localparam int LP3 = 4;

  typedef struct packed {
    logic [3:0] sh;
    logic       li;
    logic       pr;
    logic       pe;
    logic [1:0] lv;
    logic [7:0] sc;
    logic [1:0] le;
    logic       go;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_n;
  logic       coll;
  logic       goal;
  logic [3:0] sh;
  logic       li;
  logic       pr;
  logic       pe;
  logic [1:0] lv;
  logic [7:0] sc;
  logic [1:0] le;
  logic       go;

  int   total = 0;
  int   bad   = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  sc_lane_scheduler #(
    .TICK_DIV    (TD),
    .LANE0_PERIOD(LP0),
    .LANE1_PERIOD(LP1),
    .LANE2_PERIOD(LP2),
    .LANE3_PERIOD(LP3),
    .LIVES_INIT  (3)
  ) dut (
    .SC_LANE_SCHEDULER_CLOCK_50           (clk),
    .SC_LANE_SCHEDULER_RESET_InHigh       (rst),
    .SC_LANE_SCHEDULER_startGame_InLow    (start_n),
    .SC_LANE_SCHEDULER_collision_InHigh   (coll),
    .SC_LANE_SCHEDULER_goal_InHigh        (goal),
    .SC_LANE_SCHEDULER_shift_OutLow       (sh),
    .SC_LANE_SCHEDULER_loadInit_OutLow    (li),
    .SC_LANE_SCHEDULER_playerReset_OutHigh(pr),
    .SC_LANE_SCHEDULER_playEnable_OutHigh (pe),
    .SC_LANE_SCHEDULER_lives_Out          (lv),
    .SC_LANE_SCHEDULER_score_Out          (sc),
    .SC_LANE_SCHEDULER_level_Out          (le),
    .SC_LANE_SCHEDULER_gameOver_OutHigh   (go)
  );

  function automatic obs_t mk(
    input logic [3:0] s, input logic l, input logic p,
    input logic e, input int lives, input int score,
    input int lvl, input logic g);
    obs_t o;
    o.sh = s;
    o.li = l;
    o.pr = p;
    o.pe = e;
    o.lv = 2'(lives);
    o.sc = 8'(score);
    o.le = 2'(lvl);
    o.go = g;
    return o;
  endfunction

  // Strobe pattern seen in PLAY cycle j (j=0 is first PLAY cycle).
  // Base tick n lands in cycle 4n-1; strobe shows one cycle later.
  function automatic logic [3:0] play_shift(
    input int j, input int lvl);
    int lp[4];
    int p;
    logic [3:0] r;
    lp[0] = LP0;
    lp[1] = LP1;
    lp[2] = LP2;
    lp[3] = LP3;
    r = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      p = lp[i] >> lvl;
      if (p == 0) p = 1;
      if (j > 0 && (j % TD) == 0 && ((j / TD) % p) == 0)
        r[i] = 1'b0;
    end
    return r;
  endfunction

  task automatic step(input string tag, input obs_t e);
    obs_t got;
    obs_t want;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    got  = {sh, li, pr, pe, lv, sc, le, go};
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, got, want);
    end
  endtask

  obs_t rst_o;

  initial begin
    rst_o   = mk(4'hF, 1, 0, 0, 0, 0, 0, 0);
    rst     = 1'b1;
    start_n = 1'b1;
    coll    = 1'b0;
    goal    = 1'b0;
    step("reset0", rst_o);
    step("reset1", rst_o);
    rst = 1'b0;
    step("idle", rst_o);
    start_n = 1'b0;
    step("load", mk(4'hF, 0, 1, 0, 3, 0, 0, 0));
    start_n = 1'b1;
    for (int j = 0; j < 52; j++)
      step("play_l0",
           mk(play_shift(j, 0), 1, 0, 1, 3, 0, 0, 0));
    // Collision and goal together on the tick cycle.
    coll = 1'b1;
    goal = 1'b1;
    step("hit_both",
         mk(play_shift(52, 0), 1, 1, 0, 2, 0, 0, 0));
    coll = 1'b0;
    goal = 1'b0;
    step("back_play", mk(4'hF, 1, 0, 1, 2, 0, 0, 0));
    goal = 1'b1;
    step("win", mk(4'hF, 1, 0, 0, 2, 0, 0, 0));
    goal = 1'b0;
    step("win_load", mk(4'hF, 0, 1, 0, 2, 1, 1, 0));
    for (int j = 0; j < 33; j++)
      step("play_l1",
           mk(play_shift(j, 1), 1, 0, 1, 2, 1, 1, 0));
    for (int k = 2; k <= 5; k++) begin
      goal = 1'b1;
      step("win_k",
           mk(4'hF, 1, 0, 0, 2, k - 1, (k - 1 > 3) ? 3 : k - 1, 0));
      goal = 1'b0;
      step("load_k",
           mk(4'hF, 0, 1, 0, 2, k, (k > 3) ? 3 : k, 0));
      step("play_k",
           mk(4'hF, 1, 0, 1, 2, k, (k > 3) ? 3 : k, 0));
    end
    coll = 1'b1;
    step("hit1", mk(4'hF, 1, 1, 0, 1, 5, 3, 0));
    coll = 1'b0;
    step("play1", mk(4'hF, 1, 0, 1, 1, 5, 3, 0));
    coll = 1'b1;
    step("hit2", mk(4'hF, 1, 1, 0, 0, 5, 3, 0));
    coll = 1'b0;
    step("gameover", mk(4'hF, 1, 0, 0, 0, 5, 3, 1));
    coll = 1'b1;
    for (int j = 0; j < 8; j++)
      step("go_hold", mk(4'hF, 1, 0, 0, 0, 5, 3, 1));
    coll = 1'b0;
    start_n = 1'b0;
    step("go_load", mk(4'hF, 0, 1, 0, 3, 0, 0, 0));
    start_n = 1'b1;
    for (int j = 0; j < 4; j++)
      step("play_r",
           mk(play_shift(j, 0), 1, 0, 1, 3, 0, 0, 0));
    // Reset lands on the cycle with a pending strobe.
    rst = 1'b1;
    step("mid_reset", rst_o);
    step("mid_reset2", rst_o);
    rst = 1'b0;
    start_n = 1'b0;
    step("rel_idle", rst_o);
    step("rel_load", mk(4'hF, 0, 1, 0, 3, 0, 0, 0));
    start_n = 1'b1;
    step("rel_play", mk(4'hF, 1, 0, 1, 3, 0, 0, 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
